// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BE_W   = 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signals of the two-port SRAM arbiter.
// slave: arbiter view; master: environment view (requesters plus SRAM).
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic              req_0;
    logic              we_0;
    logic [ADDR_W-1:0] addr_0;
    logic [DATA_W-1:0] wdata_0;
    logic [BE_W-1:0]   be_n_0;
    logic              ack_0;
    logic [DATA_W-1:0] rdata_0;

    logic              req_1;
    logic              we_1;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] wdata_1;
    logic [BE_W-1:0]   be_n_1;
    logic              ack_1;
    logic [DATA_W-1:0] rdata_1;

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [DATA_W-1:0] sram_dq_in;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    logic              busy;

    modport slave (
        input  req_0, we_0, addr_0, wdata_0, be_n_0,
        input  req_1, we_1, addr_1, wdata_1, be_n_1,
        input  sram_dq_in,
        output ack_0, rdata_0, ack_1, rdata_1,
        output sram_addr, sram_dq_out, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output busy
    );

    modport master (
        output req_0, we_0, addr_0, wdata_0, be_n_0,
        output req_1, we_1, addr_1, wdata_1, be_n_1,
        output sram_dq_in,
        input  ack_0, rdata_0, ack_1, rdata_1,
        input  sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  busy
    );

endinterface

// File: rtl/sram_arb_pick.sv
// Grant picker for the two requesters.
// SRAM_ARB_ROUND_ROBIN_EN defined: round-robin on ties using a last-granted register.
// Undefined: fixed priority, port 0 (video) over port 1, no state.
module sram_arb_pick (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_take,
    output logic       o_valid,
    output logic       o_sel
);

    assign o_valid = |i_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic r_last;

    // Remember the most recent winner; reset to port 1 so port 0 wins the first tie
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= 1'b1;
        end else if (i_take) begin
            r_last <= o_sel;
        end
    end

    // Tie goes to the port not granted last; otherwise the lone requester wins
    always_comb begin
        o_sel = 1'b0;
        if (i_req == 2'b11) begin
            o_sel = ~r_last;
        end else begin
            o_sel = ~i_req[0];
        end
    end
`else
    // Port 0 wins whenever it requests
    assign o_sel = ~i_req[0];

    logic w_unused;
    assign w_unused = ^{i_clk, i_reset, i_take};
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port asynchronous-SRAM arbiter: IDLE -> ACCESS (ACCESS_CYCLES) -> DONE.
// All SRAM outputs are registered; DONE is a bus-turnaround cycle carrying the ack.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration (see sram_arb_pick).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic          clk_50,
    input  logic          reset,
    sram_arbiter_if.slave bus
);

    localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

    arb_state_e        r_state;
    arb_state_e        w_state_d;
    logic [3:0]        r_cnt;
    logic              r_sel;
    logic              r_we;
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_rdata_0;
    logic [DATA_W-1:0] r_rdata_1;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_dq_out;
    logic              r_dq_oe;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic [BE_W-1:0]   r_be_n;

    logic              w_valid;
    logic              w_sel;
    logic              w_take;
    logic              w_last;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [BE_W-1:0]   w_be_n;

    sram_arb_pick u_pick (
        .i_clk   (clk_50),
        .i_reset (reset),
        .i_req   ({bus.req_1, bus.req_0}),
        .i_take  (w_take),
        .o_valid (w_valid),
        .o_sel   (w_sel)
    );

    assign w_take = (r_state == StIdle) && w_valid;
    assign w_last = (r_cnt == LastCnt);

    // Operands of the port the picker selected
    always_comb begin
        w_we    = bus.we_0;
        w_addr  = bus.addr_0;
        w_wdata = bus.wdata_0;
        w_be_n  = bus.be_n_0;
        if (w_sel) begin
            w_we    = bus.we_1;
            w_addr  = bus.addr_1;
            w_wdata = bus.wdata_1;
            w_be_n  = bus.be_n_1;
        end
    end

    // State register
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (w_valid) w_state_d = StAccess;
            StAccess: if (w_last) w_state_d = StDone;
            StDone:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Grant latch, access counter, registered SRAM strobes, read capture and ack
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_sel       <= 1'b0;
            r_we        <= 1'b0;
            r_ack       <= 2'b00;
            r_rdata_0   <= '0;
            r_rdata_1   <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= '1;
        end else begin
            r_ack <= 2'b00;
            unique case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        // Operands are sampled only here, so later changes are ignored
                        r_cnt       <= 4'd0;
                        r_sel       <= w_sel;
                        r_we        <= w_we;
                        r_sram_addr <= w_addr;
                        r_be_n      <= w_be_n;
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= w_we;
                        r_we_n      <= ~w_we;
                        r_dq_oe     <= w_we;
                        if (w_we) begin
                            r_dq_out <= w_wdata;
                        end
                    end
                end
                StAccess: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_last) begin
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_be_n  <= '1;
                        r_dq_oe <= 1'b0;
                        r_ack[r_sel] <= 1'b1;
                        if (!r_we) begin
                            if (r_sel) begin
                                r_rdata_1 <= bus.sram_dq_in;
                            end else begin
                                r_rdata_0 <= bus.sram_dq_in;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ack_0       = r_ack[0];
    assign bus.ack_1       = r_ack[1];
    assign bus.rdata_0     = r_rdata_0;
    assign bus.rdata_1     = r_rdata_1;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_ce_n   = r_ce_n;
    assign bus.sram_oe_n   = r_oe_n;
    assign bus.sram_we_n   = r_we_n;
    assign bus.sram_ub_n   = r_be_n[1];
    assign bus.sram_lb_n   = r_be_n[0];
    assign bus.busy        = (r_state != StIdle);

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, range 1..15: number of cycles the SRAM strobes are held per access.
REQ-002 SHALL have ports `clk_50  in  1  system clock`, then `reset  in  1  synchronous active-high reset`; all logic is on one clock, clk_50 rising edge.
REQ-003 SHALL have per-requester ports for p = 0,1:
- `req_p  in  1  request`
- `we_p  in  1  1 = write`
- `addr_p  in  20  word address`
- `wdata_p  in  16  write data`
- `be_n_p  in  2  byte enables, active low`
- `ack_p  out  1  one-cycle completion pulse`
- `rdata_p  out  16  read data`
REQ-004 SHALL have SRAM ports:
- `sram_addr  out  20`
- `sram_dq_out  out  16`
- `sram_dq_oe  out  1  tristate enable`
- `sram_dq_in  in  16`
- `sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each`
REQ-005 SHALL have `busy  out  1`, high in any state except IDLE.

Function
REQ-006 SHALL implement states IDLE, ACCESS, DONE.
REQ-007 In IDLE with any req_p high, SHALL select one requester, latch its we/addr/wdata/be_n, clear the cycle counter, and enter ACCESS on the next edge.
REQ-008 Default selection SHALL be fixed priority: port 0 (video) over port 1.
REQ-009 In ACCESS, all SRAM outputs SHALL be registered:
- ce_n = 0; ub_n/lb_n = latched be_n.
- Read: oe_n = 0, we_n = 1, dq_oe = 0.
- Write: oe_n = 1, we_n = 0, dq_oe = 1, dq_out = latched wdata.
REQ-010 ACCESS SHALL last exactly ACCESS_CYCLES cycles, counted by a 4-bit counter.
REQ-011 On the last ACCESS cycle, a read SHALL capture sram_dq_in into rdata of the granted port.
REQ-012 In DONE, ack of the granted port SHALL be high for exactly one cycle.
- rdata of the granted port is valid in that cycle; rdata of the other port is unchanged.
- All SRAM strobes are deasserted (ce_n = oe_n = we_n = ub_n = lb_n = 1, dq_oe = 0) as a bus-turnaround cycle.
- The next state is always IDLE.
REQ-013 Latency: a request seen in IDLE at cycle 0 SHALL be acked at cycle ACCESS_CYCLES+1. Back-to-back throughput SHALL be one access per ACCESS_CYCLES+2 cycles.
REQ-014 A requester SHALL hold req and its operands stable until ack. Operand changes after grant SHALL be ignored. Dropping req after grant SHALL NOT abort the access.
REQ-015 A request that stays high and is not granted SHALL remain pending with no loss or duplication. req sampled high in the DONE cycle of its own ack SHALL be treated as a new request.
REQ-016 ack_0 and ack_1 SHALL never be high in the same cycle.
REQ-017 sram_we_n and sram_oe_n SHALL never both be 0.
REQ-018 sram_dq_oe SHALL be 1 only while sram_we_n = 0.

Reset
REQ-019 A synchronous reset SHALL force, regardless of state (including mid-ACCESS):
- State IDLE, counter 0.
- ack_p = 0, rdata_p = 0, busy = 0.
- sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0.
- All SRAM strobes = 1.
REQ-020 An access interrupted by reset SHALL produce no ack.

Configuration
REQ-021 Macro SRAM_ARB_ROUND_ROBIN_EN, when defined, SHALL replace fixed priority with round-robin.
- A 1-bit last-granted register is updated at each grant and reset to port 1, so port 0 wins the first tie.
- On simultaneous requests, the port not granted last wins.
REQ-022 When SRAM_ARB_ROUND_ROBIN_EN is undefined, arbitration SHALL be fixed priority per REQ-008, and no last-granted register SHALL exist.

Structure
REQ-023 Package sram_arb_pkg SHALL hold the state enum and the constants ADDR_W = 20, DATA_W = 16, BE_W = 2.
REQ-024 Grant selection SHALL live in sub-module sram_arb_pick: a combinational picker with registered last-grant state when round-robin is enabled. The FSM and SRAM drivers stay in sram_arbiter.

Verification
REQ-025 The bench SHALL cover these scenarios, with ACCESS_CYCLES = 2 unless stated:
- Port-1 write to addr 0x12345, data 0xBEEF, be_n 00 -> we_n low for 2 cycles, dq_oe high, ack_1 at cycle 3.
- Port-1 read of addr 0x12345 -> ack_1 with rdata_1 = 0xBEEF.
- req_0 and req_1 raised in the same cycle, fixed priority -> ack_0 then ack_1, 4 cycles apart, never coincident.
- Same stimulus with SRAM_ARB_ROUND_ROBIN_EN and both requests held high for 4 accesses -> grants alternate 0,1,0,1.
- reset asserted in the second ACCESS cycle -> next cycle all strobes = 1, busy = 0, no ack.
- ACCESS_CYCLES = 5, port-0 read with be_n = 10 -> lb_n = 0, ub_n = 1 for 5 cycles, ack_0 at cycle 6.
